// File: rtl/zap_wb_mem_responder.sv
// Wishbone B3 responder RAM: classic and incrementing-burst cycles, byte lanes, first ack after 1+WAIT_STATES cycles.
// Bursts stream one beat per cycle while stb is held; a low stb stalls the burst with no ack and no pointer movement.
module zap_wb_mem_responder #(
   parameter int DEPTH       = 1024,
   parameter int WAIT_STATES = 0
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_wb_cyc,
   input  logic        i_wb_stb,
   input  logic        i_wb_we,
   input  logic [31:0] i_wb_adr,
   input  logic [31:0] i_wb_dat,
   input  logic [3:0]  i_wb_sel,
   input  logic [2:0]  i_wb_cti,
   output logic [31:0] o_wb_dat,
   output logic        o_wb_ack,
   output logic        o_wb_err
);

   localparam int          AW      = $clog2(DEPTH);
   localparam logic [3:0]  WS      = 4'(WAIT_STATES);
   localparam logic [31:0] DEPTH_W = 32'(DEPTH);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_SINGLE, ST_BURST} state_t;

   state_t         state;
   logic [31:0]    ptr;
   logic [3:0]     wcnt;
   logic           ack_q;
   logic [31:0]    dat_q;
   logic [31:0]    mem [DEPTH];

   logic           req;
   logic [31:0]    widx;
   logic [31:0]    ptr_nx;
   logic           ptr_ok;
   logic           beat;
   logic           wr_en;
   logic [AW-1:0]  wr_idx;
   logic [AW-1:0]  rd_idx;
   logic [31:0]    rd_word;
   logic           unused_adr;

   assign req        = i_wb_cyc & i_wb_stb;
   assign widx       = {2'b00, i_wb_adr[31:2]};
   assign ptr_nx     = ptr + 32'd1;
   assign ptr_ok     = (ptr < DEPTH_W);
   assign unused_adr = ^i_wb_adr[1:0];

   // Single responses are fully registered; burst beats are additionally qualified by the live strobe.
   assign beat     = ack_q & ((state == ST_BURST) ? req : 1'b1);
   assign o_wb_ack = beat & ptr_ok;
   assign o_wb_err = beat & ~ptr_ok;
   assign o_wb_dat = dat_q;

   assign wr_en  = o_wb_ack & req & i_wb_we & ~i_reset;
   assign wr_idx = ptr[AW-1:0];

   always_comb begin
      case (state)
         ST_IDLE:  rd_idx = widx[AW-1:0];
         ST_BURST: rd_idx = ptr_nx[AW-1:0];
         default:  rd_idx = ptr[AW-1:0];
      endcase
      rd_word = mem[rd_idx];
      // A beat being written this cycle wins over the stale RAM word on the read path.
      if (wr_en && (wr_idx == rd_idx)) begin
         for (int b = 0; b < 4; b++) begin
            if (i_wb_sel[b]) rd_word[8*b +: 8] = i_wb_dat[8*b +: 8];
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (wr_en) begin
         for (int b = 0; b < 4; b++) begin
            if (i_wb_sel[b]) mem[wr_idx][8*b +: 8] <= i_wb_dat[8*b +: 8];
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state <= ST_IDLE;
         ptr   <= 32'd0;
         wcnt  <= 4'd0;
         ack_q <= 1'b0;
         dat_q <= 32'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               ack_q <= 1'b0;
               if (req) begin
                  ptr   <= widx;
                  dat_q <= rd_word;
                  if (WS != 4'd0) begin
                     wcnt  <= WS;
                     state <= ST_WAIT;
                  end else begin
                     ack_q <= 1'b1;
                     state <= (i_wb_cti == 3'b010) ? ST_BURST : ST_SINGLE;
                  end
               end
            end
            ST_WAIT: begin
               wcnt <= wcnt - 4'd1;
               if (!req) begin
                  state <= ST_IDLE;
               end else if (wcnt == 4'd1) begin
                  ack_q <= 1'b1;
                  dat_q <= rd_word;
                  state <= (i_wb_cti == 3'b010) ? ST_BURST : ST_SINGLE;
               end
            end
            ST_SINGLE: begin
               ack_q <= 1'b0;
               state <= ST_IDLE;
            end
            ST_BURST: begin
               if (!i_wb_cyc || o_wb_err) begin
                  ack_q <= 1'b0;
                  state <= ST_IDLE;
               end else if (o_wb_ack) begin
                  ptr   <= ptr_nx;
                  dat_q <= rd_word;
                  if (i_wb_cti == 3'b111) begin
                     ack_q <= 1'b0;
                     state <= ST_IDLE;
                  end
               end
            end
            default: begin
               ack_q <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

`ifndef SYNTHESIS
   // The initiator is expected to present incrementing addresses; the RAM itself follows ptr regardless.
   always @(posedge i_clk) begin
      if (!i_reset && (state == ST_BURST) && o_wb_ack)
         assert (widx == ptr) else $error("burst address does not follow internal pointer");
   end
`endif

endmodule

// File: tb/tb_zap_wb_mem_responder.sv
// Bench for zap_wb_mem_responder: two instances (0 and 3 wait states) behind one shared master.
module tb_zap_wb_mem_responder;

   localparam int DEPTH = 1024;
   localparam int WS_A  = 0;
   localparam int WS_B  = 3;

   logic        clk   = 1'b0;
   logic        rst   = 1'b1;
   logic        cyc   = 1'b0;
   logic        stb   = 1'b0;
   logic        we    = 1'b0;
   logic [31:0] adr   = 32'd0;
   logic [31:0] wdat  = 32'd0;
   logic [3:0]  sel   = 4'd0;
   logic [2:0]  cti   = 3'd0;
   logic        which = 1'b0;

   logic [31:0] dat0, dat3, dat_m;
   logic        ack0, ack3, err0, err3, ack_m, err_m;

   int checks = 0;
   int errors = 0;

   logic [31:0] mm  [2][DEPTH];
   logic [3:0]  mvb [2][DEPTH];

   assign ack_m = which ? ack3 : ack0;
   assign err_m = which ? err3 : err0;
   assign dat_m = which ? dat3 : dat0;

   always #5 clk = ~clk;

   zap_wb_mem_responder #(.DEPTH(DEPTH), .WAIT_STATES(WS_A)) u_ws0 (
      .i_clk(clk), .i_reset(rst), .i_wb_cyc(cyc & ~which), .i_wb_stb(stb), .i_wb_we(we),
      .i_wb_adr(adr), .i_wb_dat(wdat), .i_wb_sel(sel), .i_wb_cti(cti),
      .o_wb_dat(dat0), .o_wb_ack(ack0), .o_wb_err(err0)
   );

   zap_wb_mem_responder #(.DEPTH(DEPTH), .WAIT_STATES(WS_B)) u_ws3 (
      .i_clk(clk), .i_reset(rst), .i_wb_cyc(cyc & which), .i_wb_stb(stb), .i_wb_we(we),
      .i_wb_adr(adr), .i_wb_dat(wdat), .i_wb_sel(sel), .i_wb_cti(cti),
      .o_wb_dat(dat3), .o_wb_ack(ack3), .o_wb_err(err3)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
      end
   endtask

   // Reference memory: byte-lane merge with per-byte knowledge of what has been written.
   function automatic void mwrite(input int d, input int idx, input logic [31:0] v, input logic [3:0] s);
      if (idx < DEPTH) begin
         for (int b = 0; b < 4; b++) begin
            if (s[b]) begin
               mm[d][idx][8*b +: 8] = v[8*b +: 8];
               mvb[d][idx][b]       = 1'b1;
            end
         end
      end
   endfunction

   task automatic bus_single(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic r_ack, output logic r_err, output logic [31:0] r_dat,
                             output int lat, output logic after);
      cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s; cti = 3'b000;
      r_ack = 1'b0; r_err = 1'b0; r_dat = 32'd0; lat = 0;
      while (lat < 40) begin
         @(posedge clk); #1; lat++;
         @(negedge clk);
         if (ack_m || err_m) begin
            r_ack = ack_m; r_err = err_m; r_dat = dat_m;
            break;
         end
      end
      @(posedge clk); #1;
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      @(negedge clk);
      after = ack_m | err_m;
      @(posedge clk); #1;
   endtask

   task automatic chk_single(input string name, input logic w, input logic [31:0] a,
                             input logic [31:0] d, input logic [3:0] s);
      logic r_ack, r_err, after;
      logic [31:0] r_dat;
      int lat, ws, di, idx;
      bit inr;
      ws  = which ? WS_B : WS_A;
      di  = which ? 1 : 0;
      idx = int'(a >> 2);
      inr = (idx < DEPTH);
      bus_single(w, a, d, s, r_ack, r_err, r_dat, lat, after);
      check({name, " lat"}, lat, 1 + ws);
      check({name, " ack"}, 32'(r_ack), 32'(inr));
      check({name, " err"}, 32'(r_err), 32'(!inr));
      check({name, " one_cycle"}, 32'(after), 32'd0);
      if (!w && inr && mvb[di][idx] == 4'hF) check({name, " dat"}, r_dat, mm[di][idx]);
      if (w && inr) mwrite(di, idx, d, s);
   endtask

   task automatic chk_burst(input string name, input int n, input logic w, input logic [31:0] a0,
                            input logic [3:0] s, input int gap_at, input int gap_len, input bit hold_after);
      int ws, di, idx, wc;
      bit done;
      logic [31:0] v;
      ws = which ? WS_B : WS_A;
      di = which ? 1 : 0;
      done = 1'b0;
      cyc = 1'b1; we = w; sel = s;
      for (int i = 0; i < n && !done; i++) begin
         adr = a0 + 32'(4 * i);
         cti = (i == n - 1) ? 3'b111 : 3'b010;
         v = $urandom;
         wdat = v;
         if (i == gap_at) begin
            stb = 1'b0;
            for (int g = 0; g < gap_len; g++) begin
               @(negedge clk);
               check({name, " gap_quiet"}, 32'(ack_m | err_m), 32'd0);
               @(posedge clk); #1;
            end
         end
         stb = 1'b1;
         idx = int'(adr >> 2);
         wc = 0;
         forever begin
            @(negedge clk);
            if (ack_m || err_m || wc >= 40) break;
            @(posedge clk); #1; wc++;
         end
         check({name, " beat_lat"}, wc, (i == 0) ? 1 + ws : 0);
         if (wc >= 40) done = 1'b1;
         if (idx < DEPTH) begin
            check({name, " ack"}, 32'(ack_m), 32'd1);
            check({name, " err"}, 32'(err_m), 32'd0);
            if (!w && mvb[di][idx] == 4'hF) check({name, " dat"}, dat_m, mm[di][idx]);
            if (w) mwrite(di, idx, v, s);
         end else begin
            check({name, " oor_ack"}, 32'(ack_m), 32'd0);
            check({name, " oor_err"}, 32'(err_m), 32'd1);
            done = 1'b1;
         end
         @(posedge clk); #1;
      end
      if (hold_after && !done) begin
         stb = 1'b1; we = 1'b0; cti = 3'b000; adr = a0 + 32'(4 * n);
         @(negedge clk);
         check({name, " after_end"}, 32'(ack_m | err_m), 32'd0);
         @(posedge clk); #1;
      end
      cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000;
      repeat (3) @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic        we;
      logic [31:0] adr;
      logic [31:0] dat;
      logic [3:0]  sel;
      logic        exp_ack;
      logic        exp_err;
      logic        chk_dat;
      logic [31:0] exp_dat;
   } vec_t;

   vec_t vt [10];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic r_ack, r_err, after;
      logic [31:0] r_dat;
      int lat, wc;

      vt[0] = '{1'b1, 32'h0000_0010, 32'hDEADBEEF, 4'hF, 1'b1, 1'b0, 1'b0, 32'h0};
      vt[1] = '{1'b0, 32'h0000_0010, 32'h0,        4'hF, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF};
      vt[2] = '{1'b1, 32'h0000_0020, 32'h11223344, 4'hF, 1'b1, 1'b0, 1'b0, 32'h0};
      vt[3] = '{1'b1, 32'h0000_0020, 32'hAABBCCDD, 4'h5, 1'b1, 1'b0, 1'b0, 32'h0};
      vt[4] = '{1'b0, 32'h0000_0020, 32'h0,        4'h3, 1'b1, 1'b0, 1'b1, 32'h11BB33DD};
      vt[5] = '{1'b1, 32'h0000_0000, 32'hA5A50000, 4'hF, 1'b1, 1'b0, 1'b0, 32'h0};
      vt[6] = '{1'b1, 32'h0000_0004, 32'h5A5A0001, 4'hF, 1'b1, 1'b0, 1'b0, 32'h0};
      vt[7] = '{1'b1, 32'h0000_1000, 32'h12345678, 4'hF, 1'b0, 1'b1, 1'b0, 32'h0};
      vt[8] = '{1'b0, 32'h0000_1000, 32'h0,        4'hF, 1'b0, 1'b1, 1'b0, 32'h0};
      vt[9] = '{1'b0, 32'h0000_0000, 32'h0,        4'hF, 1'b1, 1'b0, 1'b1, 32'hA5A50000};

      for (int d = 0; d < 2; d++)
         for (int i = 0; i < DEPTH; i++) begin
            mm[d][i]  = 32'd0;
            mvb[d][i] = 4'd0;
         end

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset ack0", 32'(ack0), 32'd0);
      check("reset err0", 32'(err0), 32'd0);
      check("reset dat0", dat0, 32'd0);
      check("reset ack3", 32'(ack3), 32'd0);
      check("reset err3", 32'(err3), 32'd0);
      check("reset dat3", dat3, 32'd0);
      @(posedge clk); #1;

      which = 1'b0;
      for (int i = 0; i < 10; i++) begin
         bus_single(vt[i].we, vt[i].adr, vt[i].dat, vt[i].sel, r_ack, r_err, r_dat, lat, after);
         check($sformatf("vec%0d lat", i), lat, 1);
         check($sformatf("vec%0d ack", i), 32'(r_ack), 32'(vt[i].exp_ack));
         check($sformatf("vec%0d err", i), 32'(r_err), 32'(vt[i].exp_err));
         check($sformatf("vec%0d one_cycle", i), 32'(after), 32'd0);
         if (vt[i].chk_dat) check($sformatf("vec%0d dat", i), r_dat, vt[i].exp_dat);
         if (vt[i].we && vt[i].exp_ack) mwrite(0, int'(vt[i].adr >> 2), vt[i].dat, vt[i].sel);
      end

      for (int i = 0; i < 4; i++) chk_single("preload40", 1'b1, 32'h40 + 32'(4 * i), 32'(i + 1), 4'hF);
      chk_burst("rd_burst4", 4, 1'b0, 32'h40, 4'hF, -1, 0, 1'b1);

      which = 1'b1;
      for (int i = 0; i < 6; i++) chk_single("ws3_preload", 1'b1, 32'h300 + 32'(4 * i), 32'h100 + 32'(i), 4'hF);
      chk_burst("ws3_rd_gap", 6, 1'b0, 32'h300, 4'hF, 3, 2, 1'b0);
      chk_burst("ws3_wr_gap", 5, 1'b1, 32'h340, 4'hF, 2, 1, 1'b0);
      chk_burst("ws3_rd_back", 5, 1'b0, 32'h340, 4'hF, -1, 0, 1'b0);

      which = 1'b0;
      chk_burst("oor_wr_burst", 3, 1'b1, 32'hFF8, 4'hF, -1, 0, 1'b0);
      chk_single("word0_kept", 1'b0, 32'h0, 32'h0, 4'hF);
      chk_single("word1_kept", 1'b0, 32'h4, 32'h0, 4'hF);
      chk_single("word3fe_rd", 1'b0, 32'hFF8, 32'h0, 4'hF);

      cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; cti = 3'b010;
      adr = 32'h200; wdat = 32'h1111_0000;
      wc = 0;
      forever begin
         @(negedge clk);
         if (ack_m || wc >= 40) break;
         @(posedge clk); #1; wc++;
      end
      check("rstmid b0 lat", wc, 1);
      mwrite(0, 128, 32'h1111_0000, 4'hF);
      @(posedge clk); #1;
      adr = 32'h204; wdat = 32'h2222_0001;
      @(negedge clk);
      check("rstmid b1 ack", 32'(ack_m), 32'd1);
      mwrite(0, 129, 32'h2222_0001, 4'hF);
      @(posedge clk); #1;
      adr = 32'h208; wdat = 32'h3333_0002; rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("rstmid ack", 32'(ack_m), 32'd0);
      check("rstmid err", 32'(err_m), 32'd0);
      check("rstmid dat", dat_m, 32'd0);
      @(posedge clk); #1;
      cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000;
      mvb[0][130] = 4'd0;
      repeat (2) @(posedge clk);
      #1;
      chk_single("rstmid word128", 1'b0, 32'h200, 32'h0, 4'hF);
      chk_single("rstmid word129", 1'b0, 32'h204, 32'h0, 4'hF);

      for (int t = 0; t < 70; t++) begin
         int word, n, gap_at, gap_len;
         logic [31:0] a;
         logic [3:0] s;
         logic w;
         which   = 1'($urandom_range(0, 1));
         word    = ($urandom_range(0, 1) == 0) ? int'($urandom_range(64, 120))
                                               : int'($urandom_range(DEPTH - 6, DEPTH + 1));
         a       = 32'(word) << 2;
         n       = int'($urandom_range(1, 5));
         w       = 1'($urandom_range(0, 1));
         s       = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom_range(1, 15));
         gap_at  = ($urandom_range(0, 2) == 0 && n > 1) ? int'($urandom_range(1, n - 1)) : -1;
         gap_len = int'($urandom_range(1, 2));
         if ($urandom_range(0, 2) == 0) chk_single("rand_single", w, a, $urandom, s);
         else chk_burst("rand_burst", n, w, a, s, gap_at, gap_len, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
